// File: rtl/clk_div_bank.sv
// clk_div_bank: CH independent programmable square-wave dividers off sys_clk.
// Ratio updates only take effect at a period boundary; sync re-phases all running lanes.

module clk_div_lane #(
  parameter int W           = 16,
  parameter int DEFAULT_DIV = 10000
) (
  input  logic         sys_clk,
  input  logic         reset,
  input  logic         en,
  input  logic         sync,
  input  logic         wr,
  input  logic [W-1:0] wr_div,
  output logic         clk_out,
  output logic         tick,
  output logic         cfg_pending
);
  localparam logic [W-1:0] DEF = W'(DEFAULT_DIV);

  logic [W-1:0] pend, act, cnt;
  logic [W-1:0] pn, act_nxt, cnt_nxt, half;
  logic         wrap;

  always_comb begin
    // pn is the value pend holds after this edge, so a write is bypassed
    // straight into any load of act on the same edge
    pn = pend;
    if (wr) pn = (wr_div < W'(2)) ? W'(2) : wr_div;
    wrap    = en && (sync || (cnt == act - W'(1)));
    act_nxt = act;
    cnt_nxt = cnt;
    if (!en) begin
      // parked one step before wrap so the first enabled edge starts a period
      act_nxt = pn;
      cnt_nxt = pn - W'(1);
    end else if (wrap) begin
      act_nxt = pn;
      cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt + W'(1);
    end
    half = (act_nxt >> 1) + W'(act_nxt[0]);
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      pend        <= DEF;
      act         <= DEF;
      cnt         <= DEF - W'(1);
      clk_out     <= 1'b0;
      tick        <= 1'b0;
      cfg_pending <= 1'b0;
    end else begin
      pend        <= pn;
      act         <= act_nxt;
      cnt         <= cnt_nxt;
      clk_out     <= en && (cnt_nxt < half);
      tick        <= en && (cnt_nxt == '0);
      cfg_pending <= (pn != act_nxt);
    end
  end
endmodule

module clk_div_bank #(
  parameter int  CH          = 4,
  parameter int  W           = 16,
  parameter int  DEFAULT_DIV = 10000,
  localparam int CW          = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          sys_clk,
  input  logic          reset,
  input  logic [CH-1:0] en,
  input  logic          sync,
  input  logic          cfg_we,
  input  logic [CW-1:0] cfg_ch,
  input  logic [W-1:0]  cfg_div,
  output logic [CH-1:0] clk_out,
  output logic [CH-1:0] tick,
  output logic [CH-1:0] cfg_pending
);
  // out-of-range cfg_ch matches no lane index, so such writes fall on the floor
  for (genvar i = 0; i < CH; i++) begin : g_lane
    localparam logic [CW-1:0] IDX = CW'(i);
    clk_div_lane #(
      .W           (W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_lane (
      .sys_clk     (sys_clk),
      .reset       (reset),
      .en          (en[i]),
      .sync        (sync),
      .wr          (cfg_we && (cfg_ch == IDX)),
      .wr_div      (cfg_div),
      .clk_out     (clk_out[i]),
      .tick        (tick[i]),
      .cfg_pending (cfg_pending[i])
    );
  end
endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboard bench for clk_div_bank: expected per-cycle clk_out/tick/cfg_pending
// patterns are queued from the divide ratio and popped as the DUT runs.
module tb_clk_div_bank;
  // five channels so that a 3-bit cfg_ch can address a non-existent channel
  localparam int CH = 5, W = 16, DEFAULT_DIV = 6, CW = 3;

  logic          sys_clk = 1'b0;
  logic          reset   = 1'b1;
  logic          sync    = 1'b0;
  logic          cfg_we  = 1'b0;
  logic [CH-1:0] en      = '0;
  logic [CW-1:0] cfg_ch  = '0;
  logic [W-1:0]  cfg_div = '0;
  logic [CH-1:0] clk_out, tick, cfg_pending;

  int checks   = 0;
  int failures = 0;

  typedef struct { logic [CH-1:0] m, c, t, pm, p; } exp_t;
  exp_t sbq[$];

  always #5 sys_clk = ~sys_clk;

  clk_div_bank #(.CH(CH), .W(W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .en          (en),
    .sync        (sync),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .clk_out     (clk_out),
    .tick        (tick),
    .cfg_pending (cfg_pending)
  );

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wr(input int ch, input int div);
    cfg_we  = 1'b1;
    cfg_ch  = CW'(ch);
    cfg_div = W'(div);
    step();
    cfg_we  = 1'b0;
  endtask

  // queue the ideal waveform of ratio n, phases k0 .. k0+cyc-1, on channels m
  task automatic push_pat(input logic [CH-1:0] m, input int n, input int k0, input int cyc,
                          input logic [CH-1:0] pm, input logic [CH-1:0] p);
    exp_t e;
    for (int k = k0; k < k0 + cyc; k++) begin
      e.m  = m;
      e.c  = ((k % n) < (n + 1) / 2) ? m : '0;
      e.t  = ((k % n) == 0) ? m : '0;
      e.pm = pm;
      e.p  = p;
      sbq.push_back(e);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    en    = '0;
    #3;
    checks++;
    if ({clk_out, tick, cfg_pending} !== '0) begin
      failures++;
      $display("FAIL reset_state got clk=%b tick=%b pend=%b want all 0", clk_out, tick, cfg_pending);
    end
    step(); step();
    checks++;
    if ({clk_out, tick, cfg_pending} !== '0) begin
      failures++;
      $display("FAIL reset_hold got clk=%b tick=%b pend=%b want all 0", clk_out, tick, cfg_pending);
    end
    reset = 1'b0;
    step(); step();
    checks++;
    if ({clk_out, tick, cfg_pending} !== '0) begin
      failures++;
      $display("FAIL idle_disabled got clk=%b tick=%b pend=%b want all 0", clk_out, tick, cfg_pending);
    end
  endtask

  task automatic test_ratio4();
    exp_t e;
    wr(0, 4);
    checks++;
    if (cfg_pending !== '0) begin
      failures++;
      $display("FAIL ratio4_idle_pend got %b want 00000", cfg_pending);
    end
    en[0] = 1'b1;
    push_pat(5'b00001, 4, 0, 12, '0, '0);
    for (int i = 0; sbq.size() > 0; i++) begin
      step();
      e = sbq.pop_front();
      checks++;
      if ((clk_out & e.m) !== e.c || (tick & e.m) !== e.t || (cfg_pending & e.pm) !== e.p) begin
        failures++;
        $display("FAIL ratio4 cyc=%0d got clk=%b tick=%b want clk=%b tick=%b", i, clk_out & e.m, tick & e.m, e.c, e.t);
      end
    end
  endtask

  task automatic test_odd5();
    exp_t e;
    wr(1, 5);
    en[1] = 1'b1;
    push_pat(5'b00010, 5, 0, 15, '0, '0);
    for (int i = 0; sbq.size() > 0; i++) begin
      step();
      e = sbq.pop_front();
      checks++;
      if ((clk_out & e.m) !== e.c || (tick & e.m) !== e.t) begin
        failures++;
        $display("FAIL odd5 cyc=%0d got clk=%b tick=%b want clk=%b tick=%b", i, clk_out & e.m, tick & e.m, e.c, e.t);
      end
    end
  endtask

  // ratio 8, write 2 mid-period, then write 3 exactly on a wrap edge
  task automatic test_glitch_free();
    exp_t e;
    en[0] = 1'b0;
    wr(0, 8);
    en[0] = 1'b1;
    push_pat(5'b00001, 8, 0, 4, 5'b00001, 5'b00000);
    push_pat(5'b00001, 8, 4, 4, 5'b00001, 5'b00001);
    push_pat(5'b00001, 2, 0, 2, 5'b00001, 5'b00000);
    push_pat(5'b00001, 3, 0, 9, 5'b00001, 5'b00000);
    for (int i = 0; sbq.size() > 0; i++) begin
      cfg_we  = (i == 4 || i == 10);
      cfg_ch  = '0;
      cfg_div = (i == 4) ? 16'd2 : 16'd3;
      step();
      cfg_we = 1'b0;
      e = sbq.pop_front();
      checks++;
      if ((clk_out & e.m) !== e.c || (tick & e.m) !== e.t || (cfg_pending & e.pm) !== e.p) begin
        failures++;
        $display("FAIL glitch cyc=%0d got clk=%b tick=%b pend=%b want clk=%b tick=%b pend=%b",
                 i, clk_out & e.m, tick & e.m, cfg_pending & e.pm, e.c, e.t, e.p);
      end
    end
  endtask

  task automatic test_sync();
    exp_t e;
    en[0] = 1'b0;
    en[2] = 1'b0;
    wr(0, 6);
    wr(2, 6);
    en[0] = 1'b1;
    step(); step();
    en[2] = 1'b1;
    step(); step(); step();
    push_pat(5'b00101, 6, 0, 12, '0, '0);
    for (int i = 0; sbq.size() > 0; i++) begin
      sync = (i == 0);
      step();
      sync = 1'b0;
      e = sbq.pop_front();
      checks++;
      if ((clk_out & e.m) !== e.c || (tick & e.m) !== e.t) begin
        failures++;
        $display("FAIL sync_align cyc=%0d got clk=%b tick=%b want clk=%b tick=%b", i, clk_out & e.m, tick & e.m, e.c, e.t);
      end
      if (i == 0) begin
        checks++;
        if (clk_out[1] !== 1'b1 || tick[1] !== 1'b1 || clk_out[4:3] !== 2'b00 || tick[4:3] !== 2'b00) begin
          failures++;
          $display("FAIL sync_others got clk=%b tick=%b want ch1 high, ch3/ch4 low", clk_out, tick);
        end
      end
    end
    en[2] = 1'b0;
    step();
    checks++;
    if (clk_out[2] !== 1'b0 || tick[2] !== 1'b0) begin
      failures++;
      $display("FAIL disable_mid got clk=%b tick=%b want 0 0", clk_out[2], tick[2]);
    end
  endtask

  task automatic test_clamp_invalid();
    exp_t e;
    int   n;
    wr(3, 0);
    wr(4, 1);
    wr(5, 7);
    checks++;
    if (cfg_pending !== '0) begin
      failures++;
      $display("FAIL invalid_ch_pend got %b want 00000", cfg_pending);
    end
    en[3] = 1'b1;
    en[4] = 1'b1;
    push_pat(5'b11000, 2, 0, 8, 5'b11111, '0);
    for (int i = 0; sbq.size() > 0; i++) begin
      step();
      e = sbq.pop_front();
      checks++;
      if ((clk_out & e.m) !== e.c || (tick & e.m) !== e.t || (cfg_pending & e.pm) !== e.p) begin
        failures++;
        $display("FAIL clamp cyc=%0d got clk=%b tick=%b pend=%b want clk=%b tick=%b pend=%b",
                 i, clk_out & e.m, tick & e.m, cfg_pending, e.c, e.t, e.p);
      end
    end
    // channel 1 must still be running at ratio 5
    n = 0;
    while (tick[1] !== 1'b1 && n < 20) begin step(); n++; end
    n = 0;
    do begin step(); n++; end while (tick[1] !== 1'b1 && n < 20);
    checks++;
    if (n !== 5) begin
      failures++;
      $display("FAIL ch1_period got %0d want 5", n);
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    int   n;
    en = '1;
    n  = 0;
    while (clk_out[0] !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (clk_out[0] !== 1'b1) begin
      failures++;
      $display("FAIL reset_precond got clk0=%b want 1", clk_out[0]);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({clk_out, tick, cfg_pending} !== '0) begin
      failures++;
      $display("FAIL async_reset got clk=%b tick=%b pend=%b want all 0", clk_out, tick, cfg_pending);
    end
    step();
    checks++;
    if ({clk_out, tick, cfg_pending} !== '0) begin
      failures++;
      $display("FAIL reset_held got clk=%b tick=%b pend=%b want all 0", clk_out, tick, cfg_pending);
    end
    reset = 1'b0;
    push_pat('1, DEFAULT_DIV, 0, 12, '1, '0);
    for (int i = 0; sbq.size() > 0; i++) begin
      step();
      e = sbq.pop_front();
      checks++;
      if ((clk_out & e.m) !== e.c || (tick & e.m) !== e.t || (cfg_pending & e.pm) !== e.p) begin
        failures++;
        $display("FAIL post_reset cyc=%0d got clk=%b tick=%b pend=%b want clk=%b tick=%b pend=%b",
                 i, clk_out, tick, cfg_pending, e.c, e.t, e.p);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog sim time exceeded, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_ratio4();
    test_odd5();
    test_glitch_free();
    test_sync();
    test_clamp_invalid();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
